iddmm_q_sched: RTL
==================

Name: iddmm_q_sched

Overview:
- Cycle-level sequencer for one IDDMM Montgomery multiplication.
- Drives the outer word counter i_cnt and the inner word counter j_cnt.
- Sequences the two q-update products per outer iteration on the shared K x K pipelined multiplier: x*y_adv, then s*p1.
- Sits between the top-level Montgomery FSM (start/done) and the q-update datapath and word-RAM address logic.

Parameters:
- K, 128, word width in bits; carried for interface consistency only.
- N, 32, number of K-bit words per operand.
- ADDR_W, $clog2(N), word address width.
- MUL_LAT, 4, cycles from multiplier operand select to result valid, including operand registers; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin an operation; ignored while busy=1.
- stall  input  1  holds the sweep phase; the counters freeze while stall=1.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the operation completes.
- i_cnt  output  ADDR_W  outer word index, 0..N-1.
- j_cnt  output  ADDR_W+1  inner word index; 0 in the q phases, 1..N in the sweep.
- mul_sel  output  2  multiplier operand select: 00 hold, 01 x*y_adv, 10 s*p1.
- q_valid  output  1  one-cycle pulse when q for the current i is on result_q_update.
- last_iter  output  1  high while i_cnt == N-1 and busy=1.

Behaviour:
Reset values:
- busy=0, done=0, i_cnt=0, j_cnt=0, mul_sel=00, q_valid=0, last_iter=0.
- State IDLE; latency counter=0.
- All outputs are registered.

States:
- IDLE: start=1 -> Q0_ISSUE; i_cnt<=0, j_cnt<=0, busy<=1.
- Q0_ISSUE: exactly one cycle, mul_sel=01 -> Q0_WAIT; latency counter loaded with MUL_LAT-1.
- Q0_WAIT: mul_sel=00; counter decrements each cycle; counter==0 -> Q1_ISSUE. This state lasts MUL_LAT cycles.
- Q1_ISSUE: exactly one cycle, mul_sel=10 -> Q1_WAIT; counter loaded with MUL_LAT-1.
- Q1_WAIT: lasts MUL_LAT cycles. q_valid=1 on its final cycle. Then -> SWEEP with j_cnt<=1.
- SWEEP:
  - Each cycle with stall=0: j_cnt increments.
  - When j_cnt==N and stall=0: if i_cnt==N-1 -> DONE; else i_cnt+1, j_cnt<=0, -> Q0_ISSUE.
  - stall=1: all counters and the state hold; no other effect.
- DONE: one cycle, done=1, busy<=0, i_cnt<=0, j_cnt<=0 -> IDLE.

Latency:
- Cycles per outer iteration with no stall: 2*MUL_LAT + 2 + N.
- The cycle after start is the first Q0_ISSUE cycle.
- done occurs N*(2*MUL_LAT+2+N) + 1 cycles after the start edge.

Rules:
- stall affects only SWEEP. It is ignored in the Q phases so the multiplier pipeline timing is never broken.
- start during busy or DONE: ignored, no queuing.
- start in the same cycle as the done pulse: ignored. A new start is accepted only in IDLE.
- mul_sel is 00 in every state other than Q0_ISSUE and Q1_ISSUE.
- Counter wrap: i_cnt never exceeds N-1 and j_cnt never exceeds N. There is no modulo wrap; exit from SWEEP is by explicit compare.
- N not a power of two: supported; all compares are against N or N-1, never against the counter width.
- Reset asserted mid-operation: immediate return to reset values. No done pulse; the partial result is discarded.

Test Plan:
1. Reset, then idle 10 cycles -> all outputs 0, mul_sel=00.
2. N=4, MUL_LAT=4; start pulse at cycle 0, stall=0:
   - mul_sel=01 at cycles 1, 15, 29, 43; mul_sel=10 at cycles 6, 20, 34, 48.
   - q_valid at cycles 10, 24, 38, 52.
   - done at cycle 57; busy high for cycles 1..56.
3. N=4, MUL_LAT=4; stall=1 for 3 cycles at the second SWEEP cycle of i=1 (j_cnt=2):
   - j_cnt holds at 2 for 3 cycles.
   - done moves to cycle 60.
   - q phases are unaffected when stall is raised during Q0_WAIT.
4. Start pulses at cycles 5 and 57 during a busy run:
   - both ignored; exactly one done pulse.
   - a start at cycle 58 (IDLE) is accepted.
5. rst_n low at cycle 30 of a run:
   - all outputs 0 asynchronously; no done pulse.
   - a later start produces a full 56-cycle sequence from i_cnt=0.
6. N=3, MUL_LAT=1:
   - per-iteration length 7; done at cycle 22.
   - j_cnt sequence per iteration 0,0,0,0,1,2,3.
   - last_iter high only while i_cnt=2.

Source files
------------

// File: rtl/iddmm_q_sched.sv
// iddmm_q_sched: cycle-level sequencer for one IDDMM Montgomery multiplication.
//
// For each outer word i it issues the two q-update products on the shared
// pipelined multiplier (x*y_adv, then s*p1), waits out the multiplier latency,
// flags q_valid, then sweeps the inner word index j over 1..N.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       one-cycle request; accepted only in IDLE
//   stall       freezes the sweep phase (ignored during the q phases)
//   busy        high from the cycle after start is accepted until done
//   done        one-cycle completion pulse
//   i_cnt       outer word index, 0..N-1
//   j_cnt       inner word index, 0 in q phases, 1..N in the sweep
//   mul_sel     multiplier operand select: 00 hold, 01 x*y_adv, 10 s*p1
//   q_valid     one-cycle pulse when q for the current i is available
//   last_iter   high while i_cnt == N-1 and busy
// All outputs are registered.
module iddmm_q_sched #(
  parameter int unsigned K       = 128,
  parameter int unsigned N       = 32,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic [1:0]        mul_sel,
  output logic              q_valid,
  output logic              last_iter
);

  if (K < 1 || MUL_LAT < 1 || MUL_LAT > 15) begin : g_param_check
    $error("iddmm_q_sched: K must be >= 1 and MUL_LAT must be in 1..15");
  end

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StQ0Issue = 3'd1;
  localparam logic [2:0] StQ0Wait  = 3'd2;
  localparam logic [2:0] StQ1Issue = 3'd3;
  localparam logic [2:0] StQ1Wait  = 3'd4;
  localparam logic [2:0] StSweep   = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  localparam logic [1:0] SelHold = 2'b00;
  localparam logic [1:0] SelXY   = 2'b01;
  localparam logic [1:0] SelSP   = 2'b10;

  localparam logic [ADDR_W-1:0] ILast   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] IOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   JLast   = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]   JOne    = (ADDR_W + 1)'(1);
  localparam logic [3:0]        LatLoad = 4'(MUL_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W:0]   j_q, j_d;
  logic [1:0]        sel_q, sel_d;
  logic              qv_q, qv_d;
  logic              last_q, last_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    i_d     = i_q;
    j_d     = j_q;
    // Select is registered, so it is set on the transition into an issue state.
    sel_d   = SelHold;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StQ0Issue;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          sel_d   = SelXY;
        end
      end
      StQ0Issue: begin
        state_d = StQ0Wait;
        lat_d   = LatLoad;
      end
      StQ0Wait: begin
        if (lat_q == '0) begin
          state_d = StQ1Issue;
          sel_d   = SelSP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StQ1Issue: begin
        state_d = StQ1Wait;
        lat_d   = LatLoad;
      end
      StQ1Wait: begin
        if (lat_q == '0) begin
          state_d = StSweep;
          j_d     = JOne;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StSweep: begin
        if (!stall) begin
          if (j_q == JLast) begin
            j_d = '0;
            if (i_q == ILast) begin
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              i_d     = '0;
            end else begin
              state_d = StQ0Issue;
              i_d     = i_q + IOne;
              sel_d   = SelXY;
            end
          end else begin
            j_d = j_q + JOne;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        i_d     = '0;
        j_d     = '0;
      end
    endcase
  end

  // Registered flags are derived from the next state so they line up with it.
  assign qv_d   = (state_d == StQ1Wait) && (lat_d == '0);
  assign last_d = busy_d && (i_d == ILast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      sel_q   <= SelHold;
      qv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      i_q     <= i_d;
      j_q     <= j_d;
      sel_q   <= sel_d;
      qv_q    <= qv_d;
      last_q  <= last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign i_cnt     = i_q;
  assign j_cnt     = j_q;
  assign mul_sel   = sel_q;
  assign q_valid   = qv_q;
  assign last_iter = last_q;

endmodule
